// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-floor elevator car controller.
package elevator_pkg;

  localparam int unsigned CNT_W = 7;
  localparam logic [1:0] MAX_FLOOR = 2'd3;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    DWELL = 2'd3
  } state_t;

endpackage

// File: rtl/elevator.sv
// Elevator car controller: moves one floor per FLOOR_TICKS cycles toward rfloor,
// then dwells DWELL_TICKS cycles before accepting a new request.
module elevator
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_TICKS = 20,
  parameter int unsigned DWELL_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       rfloor,
  output logic [1:0]       current_floor,
  output logic             up,
  output logic             down,
  output logic             stop,
  output logic [CNT_W-1:0] counter
);

  localparam logic [CNT_W-1:0] FloorLast = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_TICKS - 1);

  state_t            state_q, state_d;
  floor_t            floor_q, floor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              up_q, up_d;
  logic              down_q, down_d;
  logic              stop_q, stop_d;

  // State, floor, counter and decoded direction flags all live in flops.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= IDLE;
      floor_q <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rfloor > floor_q) begin
          state_d = UP;
        end else if (rfloor < floor_q) begin
          state_d = DOWN;
        end
      end
      UP: begin
        if (cnt_q == FloorLast) begin
          cnt_d = '0;
          if (floor_q != MAX_FLOOR) begin
            floor_d = floor_q + 2'd1;
          end
          // Keep climbing only if the request is still above; never reverse without a dwell.
          state_d = (rfloor > floor_d && floor_d != MAX_FLOOR) ? UP : DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (cnt_q == FloorLast) begin
          cnt_d = '0;
          if (floor_q != 2'd0) begin
            floor_d = floor_q - 2'd1;
          end
          state_d = (rfloor < floor_d && floor_d != 2'd0) ? DOWN : DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == DwellLast) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flags are decoded from the next state so they land in flops alongside it.
  always_comb begin
    up_d   = 1'b0;
    down_d = 1'b0;
    stop_d = 1'b0;
    unique case (state_d)
      UP:      up_d   = 1'b1;
      DOWN:    down_d = 1'b1;
      default: stop_d = 1'b1;
    endcase
  end

  assign current_floor = floor_q;
  assign counter       = cnt_q;
  assign up            = up_q;
  assign down          = down_q;
  assign stop          = stop_q;

endmodule

// File: tb/tb_elevator.sv
// Directed self-checking bench for the elevator controller (20-cycle transit, 10-cycle dwell).
module tb_elevator;

  logic       clk;
  logic       reset_n;
  logic [1:0] rfloor;
  logic [1:0] current_floor;
  logic       up;
  logic       down;
  logic       stop;
  logic [6:0] counter;

  int total = 0;
  int bad   = 0;
  int ups;
  int downs;

  elevator #(
    .FLOOR_TICKS(20),
    .DWELL_TICKS(10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rfloor       (rfloor),
    .current_floor(current_floor),
    .up           (up),
    .down         (down),
    .stop         (stop),
    .counter      (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count up/down cycles from the current negedge until stop rises.
  task automatic travel(output int n_up, output int n_dn);
    int i;
    n_up = 0;
    n_dn = 0;
    for (i = 0; i < 500; i++) begin
      if (stop) break;
      if (up) n_up++;
      if (down) n_dn++;
      tick();
    end
    if (i == 500) check("travel_timeout", 32'd0, 32'd1);
  endtask

  // From the first dwell cycle, expect counter 9 then IDLE with counter 0.
  task automatic dwell(input string tag);
    check({tag, "_dwell_cnt0"}, counter, 0);
    tick_n(9);
    check({tag, "_dwell_cnt9"}, counter, 9);
    tick();
    check({tag, "_idle_cnt"}, counter, 0);
    check({tag, "_idle_stop"}, stop, 1);
  endtask

  always @(negedge clk) begin
    check("onehot", $countones({up, down, stop}), 1);
  end

  initial begin
    reset_n = 1'b1;
    rfloor  = 2'd0;
    tick_n(2);
    check("rst_floor", current_floor, 0);
    check("rst_cnt", counter, 0);
    check("rst_stop", stop, 1);
    check("rst_up", up, 0);
    check("rst_down", down, 0);

    // 0 -> 1
    reset_n = 1'b0;
    rfloor  = 2'd1;
    tick();
    check("t1_up", up, 1);
    check("t1_cnt", counter, 0);
    travel(ups, downs);
    check("t1_ups", ups, 20);
    check("t1_floor", current_floor, 1);
    dwell("t1");

    // 1 -> 3 through floor 2
    rfloor = 2'd3;
    tick();
    check("t2_up", up, 1);
    tick_n(20);
    check("t2_mid_floor", current_floor, 2);
    check("t2_mid_up", up, 1);
    travel(ups, downs);
    check("t2_ups", ups, 20);
    check("t2_downs", downs, 0);
    check("t2_floor", current_floor, 3);
    dwell("t2");

    // 3 -> 2, then 2 -> 0
    rfloor = 2'd2;
    tick();
    check("t3_down", down, 1);
    travel(ups, downs);
    check("t3_downs", downs, 20);
    check("t3_floor", current_floor, 2);
    dwell("t3");
    rfloor = 2'd0;
    tick();
    travel(ups, downs);
    check("t3b_downs", downs, 40);
    check("t3b_ups", ups, 0);
    check("t3b_floor", current_floor, 0);
    dwell("t3b");

    // Reverse request at counter 10: finish floor 1, dwell, then come back down
    rfloor = 2'd3;
    tick();
    tick_n(10);
    check("t4_cnt10", counter, 10);
    rfloor = 2'd0;
    travel(ups, downs);
    check("t4_ups", ups, 10);
    check("t4_floor", current_floor, 1);
    dwell("t4");
    tick();
    check("t4_down", down, 1);
    travel(ups, downs);
    check("t4_downs", downs, 20);
    check("t4_floor0", current_floor, 0);
    dwell("t4b");

    // Async reset at floor 2, counter 7
    rfloor = 2'd3;
    tick();
    tick_n(47);
    check("t5_pre_floor", current_floor, 2);
    check("t5_pre_cnt", counter, 7);
    #2 reset_n = 1'b1;
    #1;
    check("t5_floor", current_floor, 0);
    check("t5_cnt", counter, 0);
    check("t5_stop", stop, 1);
    check("t5_up", up, 0);
    check("t5_down", down, 0);
    tick();
    rfloor  = 2'd0;
    reset_n = 1'b0;

    // Request equals current floor: no motion
    for (int k = 0; k < 50; k++) begin
      tick();
      check("t6_stop", stop, 1);
      check("t6_cnt", counter, 0);
      check("t6_floor", current_floor, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
